// File: rtl/date_stream_arbiter_pkg.sv
// Shared definitions for the date-stream arbiter slice.
//   - FSM state encoding (IDLE/LOAD/FEED/SAMPLE/RESP)
//   - default string terminator and buffer depth
//   - ASCII constants used when reasoning about date strings
package date_stream_arbiter_pkg;

  typedef logic [7:0] char_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FEED   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam char_t TERM_DEFAULT   = 8'h0A;
  localparam int    MAXLEN_DEFAULT = 16;

  localparam char_t ASCII_0     = 8'h30;
  localparam char_t ASCII_9     = 8'h39;
  localparam char_t ASCII_SLASH = 8'h2F;

  function automatic logic is_digit(input char_t c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/date_char_buf.sv
// String buffer: MAXLEN x 8 chars, filled in order through a write pointer
// (the char count) and replayed through a separate read pointer.
//   clk, reset : clock, synchronous active-high reset
//   clr        : drop the stored string (count and ovf to 0)
//   wr_en      : store wr_char at position count; past MAXLEN it is dropped
//                and ovf is raised instead
//   rd_rst     : rewind the read pointer to 0
//   rd_adv     : step the read pointer by one
//   rd_char    : char under the read pointer
//   rd_last    : read pointer is on the final stored char
//   empty      : no chars stored
//   ovf        : at least one char was dropped for lack of space
module date_char_buf
  import date_stream_arbiter_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  logic  wr_en,
  input  char_t wr_char,
  input  logic  rd_rst,
  input  logic  rd_adv,
  output char_t rd_char,
  output logic  rd_last,
  output logic  empty,
  output logic  ovf
);

  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int CW = $clog2(MAXLEN + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] rd_ptr;
  logic          has_room;
  char_t         mem [MAXLEN];

  assign has_room = (count < CW'(MAXLEN));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (wr_en) begin
      if (has_room) count <= count + CW'(1);
      else          ovf   <= 1'b1;
    end
  end

  // Storage needs no reset: it is only read back below count.
  always_ff @(posedge clk) begin
    if (wr_en && has_room) mem[count[AW-1:0]] <= wr_char;
  end

  always_ff @(posedge clk) begin
    if (reset || rd_rst) rd_ptr <= '0;
    else if (rd_adv)     rd_ptr <= rd_ptr + CW'(1);
  end

  assign rd_char = mem[rd_ptr[AW-1:0]];
  assign rd_last = (rd_ptr == count - CW'(1));
  assign empty   = (count == '0);

endmodule

// File: rtl/date_stream_arbiter.sv
// Shares a single ASCII date recogniser between two char-stream requesters.
// A granted requester's string is buffered up to its terminator, then
// replayed back-to-back into the recogniser (which is held in reset outside
// the replay), and the verdict is returned tagged with the requester id.
//   clk, reset            : clock, synchronous active-high reset
//   req0_valid/char/ready : requester 0 char stream (valid/ready handshake)
//   req1_valid/char/ready : requester 1 char stream
//   chk_rst, chk_char     : recogniser reset and char input
//   chk_out               : recogniser verdict (Moore)
//   res_valid             : one-cycle result strobe
//   res_id, res_ok        : owning requester and verdict, held until next result
module date_stream_arbiter
  import date_stream_arbiter_pkg::*;
#(
  parameter char_t TERM   = TERM_DEFAULT,
  parameter int    MAXLEN = MAXLEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  output logic       chk_rst,
  output logic [7:0] chk_char,
  input  logic       chk_out,
  output logic       res_valid,
  output logic       res_id,
  output logic       res_ok
);

  logic [2:0]      state;
  logic            grant_id;
  logic            last_grant;
  logic            win;
  logic [1:0]      req_vld;
  logic [1:0][7:0] req_chr;
  logic            hs;
  logic            term_hs;
  logic            data_hs;
  char_t           hs_char;
  logic            buf_clr;
  logic            rd_adv;
  char_t           rd_char;
  logic            rd_last;
  logic            empty;
  logic            ovf;

  assign req_vld = {req1_valid, req0_valid};
  assign req_chr = {req1_char, req0_char};

  // Round robin: on a tie the requester that did not win last time goes;
  // otherwise whichever one is asking.
  assign win = (&req_vld) ? ~last_grant : req_vld[1];

  assign hs      = (state == ST_LOAD) && req_vld[grant_id];
  assign hs_char = req_chr[grant_id];
  assign term_hs = hs && (hs_char == TERM);
  assign data_hs = hs && (hs_char != TERM);
  assign buf_clr = (state == ST_RESP);
  assign rd_adv  = (state == ST_FEED);

  date_char_buf #(.MAXLEN(MAXLEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (data_hs),
    .wr_char (hs_char),
    .rd_rst  (term_hs),
    .rd_adv  (rd_adv),
    .rd_char (rd_char),
    .rd_last (rd_last),
    .empty   (empty),
    .ovf     (ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      res_id     <= 1'b0;
      res_ok     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_vld) begin
            grant_id   <= win;
            last_grant <= win;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (term_hs) begin
            // Result fields only move on entry to RESP so they stay stable
            // between results.
            if (ovf || empty) begin
              res_id <= grant_id;
              res_ok <= 1'b0;
              state  <= ST_RESP;
            end else begin
              state  <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (rd_last) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          res_id <= grant_id;
          res_ok <= chk_out;
          state  <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = (state == ST_LOAD) && !grant_id;
  assign req1_ready = (state == ST_LOAD) &&  grant_id;
  // Recogniser runs only during replay and the sample cycle, so every replay
  // starts from its initial state.
  assign chk_rst    = !((state == ST_FEED) || (state == ST_SAMPLE));
  assign chk_char   = (state == ST_FEED) ? rd_char : 8'h00;
  assign res_valid  = (state == ST_RESP);

endmodule

// File: tb/tb_date_stream_arbiter.sv
// Bench for date_stream_arbiter: a behavioural date recogniser stub on the
// chk_* side, directed scenarios plus randomized strings, and a result
// monitor that compares each result against a per-requester expectation.
module tb_date_stream_arbiter;
  import date_stream_arbiter_pkg::*;

  localparam int         MAXLEN = 16;
  localparam logic [7:0] TERM   = 8'h0A;

  typedef logic [7:0] chq_t [$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
  logic       req0_ready, req1_ready;
  logic       chk_rst;
  logic [7:0] chk_char;
  logic       chk_out = 1'b0;
  logic       res_valid, res_id, res_ok;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  chq_t exp_str   [2];
  bit   exp_acc   [2];
  bit   exp_okv   [2];
  int   exp_lat   [2];
  int   start_cyc [2];
  int   issued    [2];
  int   done      [2];
  int   order_q   [$];

  date_stream_arbiter #(.TERM(TERM), .MAXLEN(MAXLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_char  (req0_char),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_char  (req1_char),
    .req1_ready (req1_ready),
    .chk_rst    (chk_rst),
    .chk_char   (chk_char),
    .chk_out    (chk_out),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_ok     (res_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A date is exactly DDDD/DD/DD (digits and slashes in fixed places).
  function automatic bit is_date(input chq_t s);
    if (s.size() != 10) return 1'b0;
    foreach (s[i]) begin
      if (i == 4 || i == 7) begin
        if (s[i] != ASCII_SLASH) return 1'b0;
      end else if (!is_digit(s[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic chq_t str2q(input string s);
    chq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic chq_t rand_date();
    chq_t q;
    for (int i = 0; i < 10; i++)
      q.push_back((i == 4 || i == 7) ? ASCII_SLASH : 8'($urandom_range(0, 9)) + ASCII_0);
    return q;
  endfunction

  function automatic chq_t rand_junk(input int len);
    chq_t q;
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 2))
        0:       q.push_back(8'($urandom_range(0, 9)) + ASCII_0);
        1:       q.push_back(ASCII_SLASH);
        default: q.push_back(8'($urandom_range(32, 126)));
      endcase
    end
    return q;
  endfunction

  // Recogniser stub: remembers every char since its reset, verdict is
  // registered (Moore) from that history.
  chq_t rq;
  always @(posedge clk) begin
    if (chk_rst) rq.delete();
    else         rq.push_back(chk_char);
    chk_out <= is_date(rq);
  end

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic drive(input int id, input logic v, input logic [7:0] c);
    if (id == 1) begin req1_valid = v; req1_char = c; end
    else         begin req0_valid = v; req0_char = c; end
  endtask

  // Send s followed by TERM from requester id. Optional bubble of bub_len
  // cycles once bub_at chars have been accepted. solo: DUT is idle and
  // uncontended, so latency is checked. track: a result is expected.
  task automatic send(input int id, input chq_t s, input int bub_at,
                      input int bub_len, input bit solo, input bit track);
    int n, idx, bl, guard;
    bit first;
    logic [7:0] c;
    n = s.size(); idx = 0; bl = bub_len; guard = 0; first = 1'b1;
    if (track) begin
      exp_str[id] = s;
      exp_acc[id] = (n > 0) && (n <= MAXLEN);
      exp_okv[id] = exp_acc[id] && is_date(s);
      exp_lat[id] = solo ? ((exp_acc[id] ? 2 * n + 3 : n + 2) + bub_len) : -1;
      issued[id]++;
    end
    while (idx <= n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (idx == bub_at && bl > 0) begin
        drive(id, 1'b0, 8'h00);
        bl--;
      end else begin
        if (idx == n) c = TERM;
        else          c = s[idx];
        drive(id, 1'b1, c);
        if (first) begin start_cyc[id] = cyc; first = 1'b0; end
        if (rdy(id)) idx++;
      end
    end
    chk("load_done", idx, n + 1);
    @(negedge clk);
    drive(id, 1'b0, 8'h00);
    if (track) begin
      guard = 0;
      while (issued[id] != done[id] && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("res_seen", done[id], issued[id]);
    end
  endtask

  // Result monitor, sampled just after the active edge.
  chq_t flog;
  chq_t el;
  int   rid;
  int   bad;
  always @(posedge clk) begin
    #1;
    if (reset) flog.delete();
    else begin
      if (!chk_rst) flog.push_back(chk_char);
      if (res_valid) begin
        rid = int'(res_id);
        chk("res_expected", int'(issued[rid] != done[rid]), 1);
        if (issued[rid] != done[rid]) begin
          el.delete();
          if (exp_acc[rid]) begin
            el = exp_str[rid];
            el.push_back(8'h00);
          end
          bad = 0;
          for (int i = 0; i < el.size() && i < flog.size(); i++)
            if (flog[i] !== el[i]) bad++;
          chk("feed_len", flog.size(), el.size());
          chk("feed_data", bad, 0);
          chk("res_ok", int'(res_ok), int'(exp_okv[rid]));
          if (exp_lat[rid] >= 0) chk("latency", cyc - start_cyc[rid], exp_lat[rid]);
          order_q.push_back(rid);
          done[rid]++;
        end
        flog.delete();
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, mode, id;
    chq_t qa, qb;
    for (int i = 0; i < 2; i++) begin issued[i] = 0; done[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_rdy0",   int'(req0_ready), 0);
    chk("rst_rdy1",   int'(req1_ready), 0);
    chk("rst_chkrst", int'(chk_rst),    1);
    chk("rst_chkchr", int'(chk_char),   0);
    chk("rst_resv",   int'(res_valid),  0);
    chk("rst_resid",  int'(res_id),     0);
    chk("rst_resok",  int'(res_ok),     0);
    reset = 1'b0;
    @(negedge clk);

    // Plain valid date: 2n+3 = 23 cycles, 10 fed chars.
    send(0, str2q("2023/12/23"), -1, 0, 1'b1, 1'b1);

    // Tie straight after reset: req0, then req1, then req0 again.
    do_reset();
    base = order_q.size();
    fork
      begin
        send(0, str2q("1999/01/01"), -1, 0, 1'b0, 1'b1);
        send(0, str2q("2000/02/29"), -1, 0, 1'b0, 1'b1);
      end
      send(1, str2q("12/12/2012"), -1, 0, 1'b0, 1'b1);
    join
    chk("tie_n", order_q.size() - base, 3);
    if (order_q.size() - base == 3) begin
      chk("tie_0", order_q[base],     0);
      chk("tie_1", order_q[base + 1], 1);
      chk("tie_2", order_q[base + 2], 0);
    end

    // Overflow (17 chars), bare terminator, bubbles, exactly MAXLEN.
    send(1, str2q("ABCDEFGHIJKLMNOPQ"), -1, 0, 1'b1, 1'b1);
    send(0, str2q(""), -1, 0, 1'b1, 1'b1);
    send(0, str2q("0000/10/23"), 5, 3, 1'b1, 1'b1);
    send(1, str2q("0123456789/ABCDE"), -1, 0, 1'b1, 1'b1);

    // Reset during replay: everything back to idle, no result.
    send(0, str2q("1234567"), -1, 0, 1'b0, 1'b0);
    chk("feed_active", int'(chk_rst), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_chkrst", int'(chk_rst),    1);
    chk("mid_chkchr", int'(chk_char),   0);
    chk("mid_rdy0",   int'(req0_ready), 0);
    chk("mid_rdy1",   int'(req1_ready), 0);
    chk("mid_resv",   int'(res_valid),  0);
    repeat (15) @(negedge clk);
    send(1, str2q("2024/02/29"), -1, 0, 1'b1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 3);
      id   = $urandom_range(0, 1);
      case (mode)
        0: send(id, rand_date(), -1, 0, 1'b1, 1'b1);
        1: send(id, rand_junk($urandom_range(0, 20)), -1, 0, 1'b1, 1'b1);
        2: begin
          qa = ($urandom_range(0, 1) == 1) ? rand_date() : rand_junk($urandom_range(0, 18));
          qb = ($urandom_range(0, 1) == 1) ? rand_date() : rand_junk($urandom_range(0, 18));
          fork
            send(0, qa, -1, 0, 1'b0, 1'b1);
            send(1, qb, -1, 0, 1'b0, 1'b1);
          join
        end
        default: send(id, rand_date(), $urandom_range(1, 9), $urandom_range(1, 4), 1'b1, 1'b1);
      endcase
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
